nco_phase_serializer: RTL and testbench
=======================================

Name: nco_phase_serializer

Overview:
- Front end of the NCO CORDIC chain; sits directly upstream of CORDIC stage 0.
- Runs a phase accumulator and adds a phase offset.
- Folds the resulting 12-bit angle into the CORDIC convergence range (±90°) and records whether the final sine/cosine must be negated.
- Serialises the folded angle LSB-first in 2-bit slices, framed by a one-cycle ready pulse, on the 2-bit stage-to-stage bus.

Parameters:
- PHASE_W, 16, phase accumulator width; must be ≥ 12. The angle is acc[PHASE_W-1:PHASE_W-12].
- ANG_W, 12, angle word width (fixed; 6 slices × 2 bits). 4096 units = 360°.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; sampled only at frame boundaries
- fcw  in  PHASE_W  frequency control word; sampled at slot 0
- poff  in  12  phase offset, two's complement; sampled at slot 0
- Rdy  out  1  frame-start pulse to stage 0
- Ain  out  2  angle slice
- Xin  out  2  X slice; constant 2'b00 (stage 0 ignores it)
- Yin  out  2  Y slice; constant 2'b00
- ISout  out  1  invert-sign flag for the frame
- busy  out  1  high while a frame is in progress (slots 0..6)

Behaviour:
- Reset (async, rst_n=0) clears:
  - accumulator acc, slot counter, angle shift register, Rdy, Ain, ISout and busy, all to 0.
  - Xin/Yin are always 0.
- Frames are 7 cycles long, slots 0..6. All outputs are registered.
- IDLE: busy=0, Rdy=0, Ain=00.
  - Each cycle with en=1 the block enters slot 0 on the next edge.
  - Consecutive frames run back-to-back with no idle cycle while en stays 1.
- Slot 0:
  - Rdy=1, Ain=00.
  - The angle is computed at the entry edge:
    - θ = (acc[PHASE_W-1:PHASE_W-12] + poff) mod 4096, read as signed 12-bit.
    - Fold: if θ > 1024, then A = θ − 2048 and IS = 1.
    - Else if θ < −1024, then A = θ + 2048 and IS = 1.
    - Else A = θ and IS = 0.
    - θ = −2048 gives A = 0 and IS = 1. θ = ±1024 is not folded.
  - A is loaded into the shift register.
  - acc ← acc + fcw, wrapping mod 2^PHASE_W.
  - The first frame after reset uses acc = 0.
- Slots 1..6: Rdy=0; Ain = A[2k+1:2k] in slot k+1, i.e. slot 1 carries bits [1:0] and slot 6 carries bits [11:10].
- ISout:
  - Updates on entry to slot 1 of frame n.
  - Holds through slot 0 of frame n+1 inclusive, which is when stage 0 captures it.
  - In IDLE it holds its last value.
- End of frame: after slot 6, go to slot 0 if en=1, else IDLE.
- en=0 mid-frame has no effect; the current frame completes.
- fcw/poff changes outside slot 0 have no effect on the frame in flight.
- busy = 1 in slots 0..6.
- Reset mid-frame aborts the frame immediately. No partial Rdy follows; the next frame after release starts from acc = 0.

Test Plan:
- Reset, en=1, fcw=0, poff=0x400:
  - Rdy pulses every 7 cycles.
  - Ain across slots 1..6 = 00,00,00,00,00,01 (A = 0x400).
  - ISout=0, busy=1 continuously.
- fcw=0, poff=0x401:
  - θ = 1025, folded to A = 0xC01.
  - Ain = 01,00,00,00,00,11; ISout=1 from slot 1.
- fcw=0, poff=0x800 → A = 0x000, ISout=1. Then poff=0xC00 → A = 0xC00, ISout=0; ISout changes only at slot 1 of that frame.
- fcw=0x1000, poff=0:
  - Successive frame angles (pre-fold) are 0, 256, 512, …
  - acc wraps 0xF000 → 0x0000 after 16 frames.
  - Check the fold at frame 5 (θ = 1280 → A = −768 = 0xD00, IS=1).
- Drop en in slot 3 → frame completes through slot 6, then IDLE with Rdy=0 and busy=0. Re-raise en → next frame continues from the held acc.
- Assert rst_n=0 in slot 4:
  - All outputs go to 0 asynchronously.
  - After release with en=1, the first frame carries θ = poff with acc = 0.

Source files
------------

// File: rtl/nco_phase_serializer.sv
// NCO front end: phase accumulator plus offset, fold into +/-90 deg, 2-bit LSB-first angle slices.
// Latency: 7-cycle frames (Rdy slot, then 6 slices); no backpressure, en sampled only at frame boundaries.
module nco_phase_serializer #(
    parameter int PHASE_W = 16,
    parameter int ANG_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [ANG_W-1:0]   poff,
    output logic               Rdy,
    output logic [1:0]         Ain,
    output logic [1:0]         Xin,
    output logic [1:0]         Yin,
    output logic               ISout,
    output logic               busy
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic signed [ANG_W-1:0] QTR = 12'sd1024;

    state_t               state, state_nxt;
    logic [2:0]           slot, slot_nxt;
    logic                 start;
    logic [PHASE_W-1:0]   acc;
    logic [ANG_W-1:0]     sr;
    logic                 is_pend;
    logic signed [ANG_W-1:0] theta;
    logic                 fold;
    logic [ANG_W-1:0]     ang;

    assign theta = acc[PHASE_W-1 -: ANG_W] + poff;
    assign fold  = (theta > QTR) || (theta < -QTR);
    // Adding or subtracting 2048 modulo 4096 is just an MSB flip.
    assign ang   = {theta[ANG_W-1] ^ fold, theta[ANG_W-2:0]};

    assign Xin  = 2'b00;
    assign Yin  = 2'b00;
    assign busy = (state == S_RUN);

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    start     = 1'b1;
                    state_nxt = S_RUN;
                    slot_nxt  = 3'd0;
                end
            end
            S_RUN: begin
                if (slot == 3'd6) begin
                    slot_nxt = 3'd0;
                    if (en) start = 1'b1;
                    else    state_nxt = S_IDLE;
                end else begin
                    slot_nxt = slot + 3'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            slot  <= 3'd0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            sr      <= '0;
            is_pend <= 1'b0;
            Rdy     <= 1'b0;
            Ain     <= 2'b00;
            ISout   <= 1'b0;
        end else if (start) begin
            acc     <= acc + fcw;
            sr      <= ang;
            is_pend <= fold;
            Rdy     <= 1'b1;
            Ain     <= 2'b00;
        end else if (state == S_RUN && slot != 3'd6) begin
            Rdy <= 1'b0;
            Ain <= sr[1:0];
            sr  <= {2'b00, sr[ANG_W-1:2]};
            // Stage 0 captures the flag at the next frame's Rdy, so it changes only here.
            if (slot == 3'd0) ISout <= is_pend;
        end else begin
            Rdy <= 1'b0;
            Ain <= 2'b00;
        end
    end

endmodule

// File: tb/tb_nco_phase_serializer.sv
// Directed bench for nco_phase_serializer with hand-computed frame contents.
module tb_nco_phase_serializer;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [15:0] fcw;
    logic [11:0] poff;
    logic        rdy, isout, busy;
    logic [1:0]  ain, xin, yin;

    int nvec = 0;
    int nerr = 0;

    logic [8:0] obs [7];

    localparam logic [11:0] OFF_POFF [5] = '{12'h400, 12'h400, 12'h401, 12'h800, 12'hC00};
    localparam logic [11:0] OFF_A    [5] = '{12'h400, 12'h400, 12'hC01, 12'h000, 12'hC00};
    localparam bit          OFF_IS   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    localparam logic [11:0] ACC_A [17] = '{12'h000, 12'h100, 12'h200, 12'h300, 12'h400, 12'hD00,
                                           12'hE00, 12'hF00, 12'h000, 12'h100, 12'h200, 12'h300,
                                           12'hC00, 12'hD00, 12'hE00, 12'hF00, 12'h000};
    localparam bit ACC_IS [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    nco_phase_serializer #(.PHASE_W(16), .ANG_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .fcw   (fcw),
        .poff  (poff),
        .Rdy   (rdy),
        .Ain   (ain),
        .Xin   (xin),
        .Yin   (yin),
        .ISout (isout),
        .busy  (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records {Rdy,Ain,Xin,Yin,busy,ISout} for the 7 slots following the next edge.
    task automatic capture_frame(input int drop_slot);
        for (int s = 0; s < 7; s++) begin
            step();
            obs[s] = {rdy, ain, xin, yin, busy, isout};
            if (s == drop_slot) en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; fcw = '0; poff = '0;
        step();
        step();
        nvec++;
        if ({rdy, ain, xin, yin, busy, isout} !== 9'b0) begin
            nerr++;
            $display("FAIL reset_state got %b want %b", {rdy, ain, xin, yin, busy, isout}, 9'b0);
        end
    endtask

    task automatic test_offsets();
        logic [8:0] exp;
        logic [1:0] sl;
        logic       prev = 1'b0;
        rst_n = 1'b1;
        en    = 1'b1;
        fcw   = 16'h0000;
        for (int f = 0; f < 5; f++) begin
            poff = OFF_POFF[f];
            capture_frame(-1);
            for (int s = 0; s < 7; s++) begin
                if (s == 0) sl = 2'b00;
                else        sl = OFF_A[f][2*s-2 +: 2];
                exp = {(s == 0), sl, 4'b0000, 1'b1, (s == 0) ? prev : OFF_IS[f]};
                nvec++;
                if (obs[s] !== exp) begin
                    nerr++;
                    $display("FAIL offsets frame%0d slot%0d got %b want %b", f, s, obs[s], exp);
                end
            end
            prev = OFF_IS[f];
        end
    endtask

    task automatic test_accum_wrap();
        logic [8:0] exp;
        logic [1:0] sl;
        logic       prev = 1'b0;
        fcw  = 16'h1000;
        poff = 12'h000;
        for (int f = 0; f < 17; f++) begin
            capture_frame(-1);
            for (int s = 0; s < 7; s++) begin
                if (s == 0) sl = 2'b00;
                else        sl = ACC_A[f][2*s-2 +: 2];
                exp = {(s == 0), sl, 4'b0000, 1'b1, (s == 0) ? prev : ACC_IS[f]};
                nvec++;
                if (obs[s] !== exp) begin
                    nerr++;
                    $display("FAIL accum frame%0d slot%0d got %b want %b", f, s, obs[s], exp);
                end
            end
            prev = ACC_IS[f];
        end
    endtask

    // acc = 0x1000 here: theta 256+1280 -> A=0xE00, then 512+1280 -> A=0xF00, both folded.
    task automatic test_en_drop();
        logic [8:0]  exp;
        logic [1:0]  sl;
        logic [11:0] a_tbl [2] = '{12'hE00, 12'hF00};
        logic        prev = 1'b0;
        poff = 12'h500;
        for (int f = 0; f < 2; f++) begin
            capture_frame(f == 0 ? 3 : -1);
            for (int s = 0; s < 7; s++) begin
                if (s == 0) sl = 2'b00;
                else        sl = a_tbl[f][2*s-2 +: 2];
                exp = {(s == 0), sl, 4'b0000, 1'b1, (s == 0) ? prev : 1'b1};
                nvec++;
                if (obs[s] !== exp) begin
                    nerr++;
                    $display("FAIL en_drop frame%0d slot%0d got %b want %b", f, s, obs[s], exp);
                end
            end
            prev = 1'b1;
            if (f == 0) begin
                for (int i = 0; i < 3; i++) begin
                    step();
                    nvec++;
                    if ({rdy, ain, xin, yin, busy, isout} !== 9'b000000001) begin
                        nerr++;
                        $display("FAIL en_drop_idle cyc%0d got %b want %b", i,
                                 {rdy, ain, xin, yin, busy, isout}, 9'b000000001);
                    end
                end
                en = 1'b1;
            end
        end
    endtask

    // acc = 0x3000, poff 0x500: theta = -2048 -> A=0, IS=1; reset lands in slot 4.
    task automatic test_reset_mid();
        logic [8:0]  exp;
        logic [1:0]  sl;
        logic [11:0] a = 12'h123;
        for (int s = 0; s < 5; s++) step();
        nvec++;
        if ({rdy, ain, xin, yin, busy, isout} !== 9'b000000011) begin
            nerr++;
            $display("FAIL pre_reset_slot4 got %b want %b", {rdy, ain, xin, yin, busy, isout}, 9'b000000011);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({rdy, ain, xin, yin, busy, isout} !== 9'b0) begin
            nerr++;
            $display("FAIL async_reset got %b want %b", {rdy, ain, xin, yin, busy, isout}, 9'b0);
        end
        poff = 12'h123;
        for (int i = 0; i < 2; i++) begin
            step();
            nvec++;
            if ({rdy, ain, xin, yin, busy, isout} !== 9'b0) begin
                nerr++;
                $display("FAIL in_reset cyc%0d got %b want %b", i, {rdy, ain, xin, yin, busy, isout}, 9'b0);
            end
        end
        rst_n = 1'b1;
        capture_frame(-1);
        for (int s = 0; s < 7; s++) begin
            if (s == 0) sl = 2'b00;
            else        sl = a[2*s-2 +: 2];
            exp = {(s == 0), sl, 4'b0000, 1'b1, 1'b0};
            nvec++;
            if (obs[s] !== exp) begin
                nerr++;
                $display("FAIL post_reset slot%0d got %b want %b", s, obs[s], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_offsets();
        test_accum_wrap();
        test_en_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
